// File: rtl/shift_reg_piso_if.sv
// Parallel-load / serial-out handshake bundle for shift_reg_piso.
// The master side is the parallel producer. The slave side is the shift register.
interface shift_reg_piso_if #(
    parameter int WIDTH = 4
) ();
    logic [WIDTH-1:0] pdi;
    logic             load;
    logic             ready;
    logic             sdo;
    logic             sdo_valid;
    logic             done;

    modport master (
        output pdi,
        output load,
        input  ready,
        input  sdo,
        input  sdo_valid,
        input  done
    );

    modport slave (
        input  pdi,
        input  load,
        output ready,
        output sdo,
        output sdo_valid,
        output done
    );
endinterface

// File: rtl/shift_reg_piso.sv
// Parallel-in, serial-out shift register with a load/ready handshake.
// An accepted word's first bit is driven on sdo on the accepting edge. The
// remaining bits follow one per clock, with no gap between them. On a
// frame's last bit, ready is high, so a new load can follow back-to-back.
// Optional feature: define PISO_PARITY_EN to append an even-parity bit. The
// parity is taken from the captured word, so FLEN becomes WIDTH+1.
module shift_reg_piso #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    shift_reg_piso_if.slave   bus
);

`ifdef PISO_PARITY_EN
    localparam int FLEN = WIDTH + 1;
`else
    localparam int FLEN = WIDTH;
`endif
    localparam int CW = $clog2(FLEN + 1);

    generate
        if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
            $error("shift_reg_piso: WIDTH must be in 2..32");
        end
    endgenerate

    typedef enum logic {
        S_IDLE,
        S_SHIFT
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_shift;
    logic [CW-1:0]    r_count;
    logic             r_sdo;
    logic             r_valid;
    logic             r_done;
`ifdef PISO_PARITY_EN
    logic             r_par;
`endif

    logic             w_last;
    logic             w_ready;
    logic             w_accept;
    logic             w_first;
    logic [WIDTH-1:0] w_rest;
    logic             w_next_bit;
    logic [WIDTH-1:0] w_shifted;
    logic             w_next_out;

    // Handshake and datapath selects, all derived from registered state.
    always_comb begin
        w_last   = (r_count == CW'(FLEN));
        w_ready  = (r_state == S_IDLE) || w_last;
        w_accept = bus.load && w_ready;

        if (MSB_FIRST) begin
            w_first    = bus.pdi[WIDTH-1];
            w_rest     = bus.pdi << 1;
            w_next_bit = r_shift[WIDTH-1];
            w_shifted  = r_shift << 1;
        end else begin
            w_first    = bus.pdi[0];
            w_rest     = bus.pdi >> 1;
            w_next_bit = r_shift[0];
            w_shifted  = r_shift >> 1;
        end

`ifdef PISO_PARITY_EN
        // Once all data bits have gone out, the parity bit follows.
        w_next_out = (r_count == CW'(WIDTH)) ? r_par : w_next_bit;
`else
        w_next_out = w_next_bit;
`endif
    end

    // Frame FSM. It owns all serial outputs. The first bit is taken from pdi
    // directly, so r_shift only holds the bits not yet sent.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_shift <= '0;
            r_count <= '0;
            r_sdo   <= 1'b0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
`ifdef PISO_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else if (w_accept) begin
            r_state <= S_SHIFT;
            r_shift <= w_rest;
            r_count <= CW'(1);
            r_sdo   <= w_first;
            r_valid <= 1'b1;
            r_done  <= 1'b0;
`ifdef PISO_PARITY_EN
            r_par   <= ^bus.pdi;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_count <= '0;
                    r_sdo   <= 1'b0;
                    r_valid <= 1'b0;
                    r_done  <= 1'b0;
                end
                S_SHIFT: begin
                    if (w_last) begin
                        r_state <= S_IDLE;
                        r_shift <= '0;
                        r_count <= '0;
                        r_sdo   <= 1'b0;
                        r_valid <= 1'b0;
                        r_done  <= 1'b0;
                    end else begin
                        r_shift <= w_shifted;
                        r_count <= r_count + CW'(1);
                        r_sdo   <= w_next_out;
                        r_valid <= 1'b1;
                        r_done  <= (r_count == CW'(FLEN - 1));
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_count <= '0;
                    r_sdo   <= 1'b0;
                    r_valid <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ready     = w_ready;
    assign bus.sdo       = r_sdo;
    assign bus.sdo_valid = r_valid;
    assign bus.done      = r_done;

endmodule

// File: tb/tb_shift_reg_piso.sv
// Testbench for shift_reg_piso. Two instances are driven with the same
// stimulus: dut_a is MSB-first and dut_b is LSB-first. Each instance is
// checked every cycle against a frame-level model. Literal sequences pin
// the model itself. Build with +define+PISO_PARITY_EN for the parity variant.
module tb_shift_reg_piso;
    localparam int W = 4;
`ifdef PISO_PARITY_EN
    localparam int FLEN = W + 1;
`else
    localparam int FLEN = W;
`endif

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [W-1:0] pdi = '0;
    logic         load = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    shift_reg_piso_if #(.WIDTH(W)) if_a ();
    shift_reg_piso_if #(.WIDTH(W)) if_b ();

    assign if_a.pdi  = pdi;
    assign if_a.load = load;
    assign if_b.pdi  = pdi;
    assign if_b.load = load;

    shift_reg_piso #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_a (
        .clk(clk), .reset_n(reset_n), .bus(if_a)
    );
    shift_reg_piso #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_b (
        .clk(clk), .reset_n(reset_n), .bus(if_b)
    );

    always #5 clk = ~clk;

    logic [1:0] d_sdo, d_valid, d_done, d_ready;
    assign d_sdo   = {if_b.sdo, if_a.sdo};
    assign d_valid = {if_b.sdo_valid, if_a.sdo_valid};
    assign d_done  = {if_b.done, if_a.done};
    assign d_ready = {if_b.ready, if_a.ready};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Frame-level model. Each accepted word becomes a list of FLEN bits.
    // Each clock advances one position through that list.
    bit m_act [2];
    int m_pos [2];
    bit m_bits[2][FLEN];

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int d = 0; d < 2; d++) begin
                m_act[d] = 1'b0;
                m_pos[d] = 0;
            end
        end else begin
            cyc++;
            for (int d = 0; d < 2; d++) begin
                if ((!m_act[d] || m_pos[d] == FLEN - 1) && load) begin
                    for (int i = 0; i < W; i++)
                        m_bits[d][i] = (d == 0) ? pdi[W-1-i] : pdi[i];
                    if (FLEN > W) m_bits[d][FLEN-1] = ^pdi;
                    m_act[d] = 1'b1;
                    m_pos[d] = 0;
                end else if (m_act[d]) begin
                    if (m_pos[d] == FLEN - 1) m_act[d] = 1'b0;
                    else m_pos[d]++;
                end
            end
        end
    end

    // Every-cycle comparison against the model, on the inactive clock edge.
    always @(negedge clk) begin
        if (reset_n) begin
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("model_sdo[%0d]", d), 32'(d_sdo[d]),
                    32'(m_act[d] ? m_bits[d][m_pos[d]] : 1'b0));
                chk($sformatf("model_valid[%0d]", d), 32'(d_valid[d]), 32'(m_act[d]));
                chk($sformatf("model_done[%0d]", d), 32'(d_done[d]),
                    32'(m_act[d] && m_pos[d] == FLEN - 1));
                chk($sformatf("model_ready[%0d]", d), 32'(d_ready[d]),
                    32'(!m_act[d] || m_pos[d] == FLEN - 1));
            end
        end
    end

    task automatic at_post();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    // One frame from IDLE. seq_a and seq_b list the bits in send order,
    // leftmost first.
    task automatic frame_lit(input string tag, input logic [W-1:0] w,
                             input logic [FLEN-1:0] seq_a, input logic [FLEN-1:0] seq_b);
        pdi  = w;
        load = 1'b1;
        for (int i = 0; i < FLEN; i++) begin
            at_post();
            chk({tag, "_sdo_a"}, 32'(if_a.sdo), 32'(seq_a[FLEN-1-i]));
            chk({tag, "_sdo_b"}, 32'(if_b.sdo), 32'(seq_b[FLEN-1-i]));
            chk({tag, "_valid"}, 32'(d_valid), 32'(2'b11));
            chk({tag, "_done"}, 32'(d_done), (i == FLEN - 1) ? 32'(2'b11) : 32'(0));
            chk({tag, "_ready"}, 32'(d_ready), (i == FLEN - 1) ? 32'(2'b11) : 32'(0));
            at_neg();
            load = 1'b0;
            pdi  = ~w;
        end
        at_post();
        chk({tag, "_idle_sdo"}, 32'(d_sdo), 32'(0));
        chk({tag, "_idle_valid"}, 32'(d_valid), 32'(0));
        chk({tag, "_idle_ready"}, 32'(d_ready), 32'(2'b11));
        at_neg();
    endtask

`ifdef PISO_PARITY_EN
    localparam logic [FLEN-1:0]   L1A = 5'b10111, L1B = 5'b11011;
    localparam logic [FLEN-1:0]   L2A = 5'b10010, L2B = 5'b10010;
    localparam logic [FLEN-1:0]   L5A = 5'b01010, L5B = 5'b10100;
    localparam logic [2*FLEN-1:0] BBA = 10'b1100000110, BBB = 10'b0011011000;
`else
    localparam logic [FLEN-1:0]   L1A = 4'b1011, L1B = 4'b1101;
    localparam logic [FLEN-1:0]   L2A = 4'b1001, L2B = 4'b1001;
    localparam logic [FLEN-1:0]   L5A = 4'b0101, L5B = 4'b1010;
    localparam logic [2*FLEN-1:0] BBA = 8'b11000011, BBB = 8'b00111100;
`endif

    initial begin
        // Reset state
        #3;
        chk("rst_sdo", 32'(d_sdo), 32'(0));
        chk("rst_valid", 32'(d_valid), 32'(0));
        chk("rst_done", 32'(d_done), 32'(0));
        at_neg();
        reset_n = 1'b1;
        at_neg();
        chk("rst_ready", 32'(d_ready), 32'(2'b11));

        // Single frames in both bit orders, with and without parity
        frame_lit("f1011", 4'b1011, L1A, L1B);
        frame_lit("f1001", 4'b1001, L2A, L2B);

        // Back-to-back frames with load held high through the last bit
        pdi  = 4'b1100;
        load = 1'b1;
        for (int i = 0; i < 2 * FLEN; i++) begin
            at_post();
            chk("bb_sdo_a", 32'(if_a.sdo), 32'(BBA[2*FLEN-1-i]));
            chk("bb_sdo_b", 32'(if_b.sdo), 32'(BBB[2*FLEN-1-i]));
            chk("bb_valid", 32'(d_valid), 32'(2'b11));
            chk("bb_done", 32'(d_done),
                (i == FLEN - 1 || i == 2 * FLEN - 1) ? 32'(2'b11) : 32'(0));
            at_neg();
            if (i == 0) pdi = 4'b0011;
            if (i == FLEN) load = 1'b0;
        end
        at_post();
        chk("bb_end_valid", 32'(d_valid), 32'(0));
        at_neg();

        // Busy load during bit 2 is ignored
        pdi  = 4'b1001;
        load = 1'b1;
        for (int i = 0; i < FLEN; i++) begin
            at_post();
            chk("busy_sdo_a", 32'(if_a.sdo), 32'(L2A[FLEN-1-i]));
            chk("busy_sdo_b", 32'(if_b.sdo), 32'(L2B[FLEN-1-i]));
            at_neg();
            load = (i == 0);
            if (i == 0) pdi = 4'b0110;
        end
        at_post();
        chk("busy_end_valid", 32'(d_valid), 32'(0));
        at_neg();

        // Asynchronous reset mid-frame, then a clean frame
        pdi  = 4'b1111;
        load = 1'b1;
        at_post();
        at_neg();
        load = 1'b0;
        at_post();
        at_neg();
        reset_n = 1'b0;
        #1;
        chk("arst_sdo", 32'(d_sdo), 32'(0));
        chk("arst_valid", 32'(d_valid), 32'(0));
        chk("arst_done", 32'(d_done), 32'(0));
        #1;
        reset_n = 1'b1;
        #1;
        chk("arst_ready", 32'(d_ready), 32'(2'b11));
        at_neg();
        frame_lit("f0101", 4'b0101, L5A, L5B);

        // Random traffic with occasional asynchronous resets
        for (int i = 0; i < 3000; i++) begin
            pdi  = W'($urandom);
            load = ($urandom_range(0, 99) < 45);
            if ($urandom_range(0, 299) == 0) begin
                reset_n = 1'b0;
                #2;
                reset_n = 1'b1;
            end
            at_neg();
        end
        load = 1'b0;
        at_neg();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
